uop_multi_queue: RTL and testbench

//  Parametrised multi-lane instruction queue between decode and rename/ROB; stores uop_pkg::uop_insn entries.

---
 rtl/uop_multi_queue.sv | 151 +++++++++++++++
 tb/tb_uop_multi_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uop_multi_queue.sv
// Multi-lane in-order uop queue between decode and rename: up to ENQ_WIDTH writes and
// DEQ_WIDTH oldest-first reads per cycle, with flush and optional HLT serialisation.

package uop_pkg;
   typedef enum logic [3:0] {
      UOP_NOP = 4'd0,
      UOP_ADD = 4'd1,
      UOP_SUB = 4'd2,
      UOP_AND = 4'd3,
      UOP_OR  = 4'd4,
      UOP_LD  = 4'd5,
      UOP_ST  = 4'd6,
      UOP_BR  = 4'd7,
      UOP_HLT = 4'd8
   } uop_op_e;

   typedef struct packed {
      uop_op_e     op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } uop_insn;
endpackage

module uop_multi_queue
   import uop_pkg::*;
#(
   parameter int DEPTH      = 32,
   parameter int ENQ_WIDTH  = 4,
   parameter int DEQ_WIDTH  = 4,
   parameter int HLT_SERIAL = 1
) (
   input  logic                               clk_in,
   input  logic                               rst_in,
   input  logic                               flush_in,
   input  logic [$clog2(ENQ_WIDTH+1)-1:0]     enq_cnt_in,
   input  uop_insn [ENQ_WIDTH-1:0]            enq_uops_in,
   output logic                               enq_ready_out,
   output logic [DEQ_WIDTH-1:0]               deq_valid_out,
   output uop_insn [DEQ_WIDTH-1:0]            deq_uops_out,
   input  logic [$clog2(DEQ_WIDTH+1)-1:0]     deq_cnt_in,
   output logic [$clog2(DEPTH+1)-1:0]         count_out,
   output logic [$clog2(DEPTH+1)-1:0]         free_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = $clog2(ENQ_WIDTH+1);
   localparam int DW = $clog2(DEQ_WIDTH+1);

   uop_insn                mem_q [DEPTH];
   logic [PW-1:0]          head_q, head_d;
   logic [PW-1:0]          tail_q, tail_d;
   logic [CW-1:0]          count_q, count_d;

   logic                   enqFire;
   logic [CW-1:0]          enqAmt;
   logic [DW-1:0]          validCnt;
   logic [DW-1:0]          deqTake;
   logic [DEQ_WIDTH-1:0]   laneValid;
   uop_insn [DEQ_WIDTH-1:0] laneUop;
   logic                   laneStop;
   logic [PW-1:0]          laneIdx;

   assign count_out     = count_q;
   assign free_out      = CW'(DEPTH) - count_q;
   assign enq_ready_out = (CW'(DEPTH) - count_q) >= CW'(ENQ_WIDTH);
   assign enqFire       = (enq_cnt_in != '0) && enq_ready_out;
   assign enqAmt        = enqFire ? CW'(enq_cnt_in) : '0;

   // A HLT past lane 0 blocks itself and everything younger; a HLT at the head goes out alone.
   always_comb begin
      laneValid = '0;
      laneUop   = '0;
      validCnt  = '0;
      laneStop  = 1'b0;
      laneIdx   = head_q;
      for (int i = 0; i < DEQ_WIDTH; i++) begin
         laneIdx = head_q + PW'(i);
         if (!laneStop && (CW'(i) < count_q)) begin
            if ((HLT_SERIAL != 0) && (mem_q[laneIdx].op == UOP_HLT)) begin
               laneStop = 1'b1;
               if (i == 0) begin
                  laneValid[i] = 1'b1;
                  laneUop[i]   = mem_q[laneIdx];
                  validCnt     = validCnt + DW'(1);
               end
            end else begin
               laneValid[i] = 1'b1;
               laneUop[i]   = mem_q[laneIdx];
               validCnt     = validCnt + DW'(1);
            end
         end else begin
            laneStop = 1'b1;
         end
      end
   end

   assign deq_valid_out = laneValid;
   assign deq_uops_out  = laneUop;
   assign deqTake       = (deq_cnt_in > validCnt) ? validCnt : deq_cnt_in;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(deqTake);
         tail_d  = tail_q + PW'(enqAmt);
         count_d = count_q + enqAmt - CW'(deqTake);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: lanes are only presented once count covers them.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         if (!rst_in && !flush_in && enqFire && (EW'(i) < enq_cnt_in)) begin
            mem_q[tail_q + PW'(i)] <= enq_uops_in[i];
         end
      end
   end

`ifndef SYNTHESIS
   // Asking for more lanes than are valid is legal and clamped, so only the lane width is bounded.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         assert (enq_cnt_in <= EW'(ENQ_WIDTH));
         assert (deq_cnt_in <= DW'(DEQ_WIDTH));
         assert (count_q <= CW'(DEPTH));
      end
   end
`endif

endmodule

// File: tb/tb_uop_multi_queue.sv
// Randomised and directed bench for uop_multi_queue, checked every cycle against a
// queue-based reference model of the program-ordered uop stream.

module tb_uop_multi_queue;
   import uop_pkg::*;

   localparam int DEPTH = 32;
   localparam int EW    = 4;
   localparam int DW    = 4;

   logic           clock    = 1'b0;
   logic           reset    = 1'b1;
   logic           flush    = 1'b0;
   logic [2:0]     enqCnt   = '0;
   logic [2:0]     deqCnt   = '0;
   uop_insn [3:0]  enqUops  = '0;
   logic           enqReady;
   logic [3:0]     deqValid;
   uop_insn [3:0]  deqUops;
   logic [5:0]     countOut;
   logic [5:0]     freeOut;

   int             assertCount = 0;
   int             failCount   = 0;
   int             nextTag     = 0;
   uop_insn        refQ [$];
   uop_insn        sentUop;

   always #5 clock = ~clock;

   uop_multi_queue #(
      .DEPTH(DEPTH), .ENQ_WIDTH(EW), .DEQ_WIDTH(DW), .HLT_SERIAL(1)
   ) dut (
      .clk_in(clock),
      .rst_in(reset),
      .flush_in(flush),
      .enq_cnt_in(enqCnt),
      .enq_uops_in(enqUops),
      .enq_ready_out(enqReady),
      .deq_valid_out(deqValid),
      .deq_uops_out(deqUops),
      .deq_cnt_in(deqCnt),
      .count_out(countOut),
      .free_out(freeOut)
   );

   // Expected lane mask: the oldest min(size,4) entries, cut at the first HLT.
   function automatic logic [3:0] expMask();
      int avail;
      int lim;
      logic [3:0] m;
      avail = (refQ.size() < DW) ? refQ.size() : DW;
      lim   = avail;
      for (int k = 0; k < avail; k++) begin
         if (refQ[k].op == UOP_HLT) begin
            lim = (k == 0) ? 1 : k;
            break;
         end
      end
      m = '0;
      for (int k = 0; k < lim; k++) m[k] = 1'b1;
      return m;
   endfunction

   function automatic uop_insn makeUop(int tag, int hltPct);
      uop_insn u;
      u.op  = (int'($urandom_range(0, 99)) < hltPct) ? UOP_HLT : uop_op_e'(4'($urandom_range(1, 7)));
      u.rd  = 5'($urandom);
      u.rs1 = 5'($urandom);
      u.rs2 = 5'($urandom);
      u.imm = 32'(tag);
      return u;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs just after the falling edge; tags advance only when the
   // producer's write is going to be taken, so a held request keeps its tags.
   task automatic applyStimulus(input int eC, input int dC, input bit fl, input int hltPct);
      @(negedge clock);
      #1;
      enqCnt = 3'(eC);
      deqCnt = 3'(dC);
      flush  = fl;
      for (int i = 0; i < EW; i++) begin
         if (i < eC) enqUops[i] = makeUop(nextTag + i, hltPct);
         else        enqUops[i] = makeUop(32'hDEAD0000 + i, 50);
      end
      if (!fl && !reset && (eC > 0) && (DEPTH - refQ.size() >= EW)) nextTag += eC;
   endtask

   // Reference model: updates the ordered stream on each rising edge.
   always @(posedge clock) begin
      int  pop;
      int  take;
      bit  fire;
      if (!reset) begin
         if (flush) begin
            refQ.delete();
         end else begin
            pop  = $countones(expMask());
            take = (int'(deqCnt) < pop) ? int'(deqCnt) : pop;
            fire = (enqCnt != 0) && (DEPTH - refQ.size() >= EW);
            for (int i = 0; i < take; i++) void'(refQ.pop_front());
            if (fire) for (int i = 0; i < int'(enqCnt); i++) refQ.push_back(enqUops[i]);
         end
      end
   end

   always @(posedge reset) refQ.delete();

   // Monitor: compares everything the DUT presents against the model, away from the edge.
   always @(negedge clock) begin
      logic [3:0] m;
      m = expMask();
      checkOutput("deqValid", 64'(deqValid), 64'(m));
      checkOutput("countOut", 64'(countOut), 64'(refQ.size()));
      checkOutput("freeOut", 64'(freeOut), 64'(DEPTH - refQ.size()));
      checkOutput("enqReady", 64'(enqReady), 64'(DEPTH - refQ.size() >= EW));
      for (int i = 0; i < DW; i++) begin
         checkOutput($sformatf("lane%0d", i), 64'(deqUops[i]), m[i] ? 64'(refQ[i]) : 64'd0);
      end
   end

   initial begin
      $display("[TB] start");
      repeat (2) @(negedge clock);
      #1 reset = 1'b0;

      // Reset dropped in mid-stream
      applyStimulus(4, 0, 0, 0);
      applyStimulus(3, 1, 0, 0);
      applyStimulus(4, 2, 0, 0);
      #2 reset = 1'b1;
      #1;
      checkOutput("rstCount", 64'(countOut), 64'd0);
      checkOutput("rstFree", 64'(freeOut), 64'd32);
      checkOutput("rstValid", 64'(deqValid), 64'd0);
      checkOutput("rstReady", 64'(enqReady), 64'd1);
      applyStimulus(0, 0, 0, 0);
      reset = 1'b0;

      // Fill to full, then one more burst that must be dropped
      repeat (8) applyStimulus(4, 0, 0, 0);
      @(posedge clock); #1;
      checkOutput("fullCount", 64'(countOut), 64'd32);
      checkOutput("fullReady", 64'(enqReady), 64'd0);
      applyStimulus(4, 0, 0, 0);
      @(posedge clock); #1;
      checkOutput("dropCount", 64'(countOut), 64'd32);
      repeat (8) applyStimulus(0, 4, 0, 0);
      applyStimulus(0, 0, 0, 0);
      @(posedge clock); #1;
      checkOutput("drainCount", 64'(countOut), 64'd0);

      // Ordered stream across the pointer wrap
      repeat (40) applyStimulus(3, 2, 0, 0);
      repeat (20) applyStimulus(0, 4, 0, 0);
      @(posedge clock); #1;
      checkOutput("wrapDrain", 64'(countOut), 64'd0);

      // Simultaneous enqueue/dequeue and over-asked dequeue
      applyStimulus(4, 0, 0, 0);
      applyStimulus(4, 0, 0, 0);
      applyStimulus(2, 0, 0, 0);
      @(posedge clock); #1;
      checkOutput("simPre", 64'(countOut), 64'd10);
      applyStimulus(4, 4, 0, 0);
      @(posedge clock); #1;
      checkOutput("simCount", 64'(countOut), 64'd10);
      applyStimulus(0, 4, 0, 0);
      applyStimulus(0, 4, 0, 0);
      @(posedge clock); #1;
      checkOutput("twoLeft", 64'(countOut), 64'd2);
      applyStimulus(0, 4, 0, 0);
      checkOutput("twoValid", 64'(deqValid), 64'b0011);
      @(posedge clock); #1;
      checkOutput("clampCount", 64'(countOut), 64'd0);

      // HLT serialisation
      applyStimulus(4, 0, 0, 0);
      enqUops[0].op = UOP_ADD;
      enqUops[1].op = UOP_SUB;
      enqUops[2].op = UOP_HLT;
      enqUops[3].op = UOP_ADD;
      @(posedge clock); #1;
      checkOutput("hltMask1", 64'(deqValid), 64'b0011);
      applyStimulus(0, 2, 0, 0);
      @(posedge clock); #1;
      checkOutput("hltMask2", 64'(deqValid), 64'b0001);
      checkOutput("hltOp", 64'(deqUops[0].op), 64'(UOP_HLT));
      applyStimulus(0, 1, 0, 0);
      @(posedge clock); #1;
      checkOutput("hltMask3", 64'(deqValid), 64'b0001);
      checkOutput("addOp", 64'(deqUops[0].op), 64'(UOP_ADD));
      applyStimulus(0, 1, 0, 0);
      @(posedge clock); #1;
      checkOutput("hltEmpty", 64'(countOut), 64'd0);

      // Flush wins over same-cycle traffic
      repeat (4) applyStimulus(4, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      @(posedge clock); #1;
      checkOutput("preFlush", 64'(countOut), 64'd17);
      applyStimulus(4, 2, 1, 0);
      @(posedge clock); #1;
      checkOutput("flushCount", 64'(countOut), 64'd0);
      checkOutput("flushValid", 64'(deqValid), 64'd0);
      checkOutput("flushFree", 64'(freeOut), 64'd32);
      applyStimulus(1, 0, 0, 0);
      sentUop = enqUops[0];
      checkOutput("noBypass", 64'(deqValid), 64'd0);
      @(posedge clock); #1;
      checkOutput("postFlushValid", 64'(deqValid), 64'b0001);
      checkOutput("postFlushUop", 64'(deqUops[0]), 64'(sentUop));

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         applyStimulus(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       ($urandom_range(0, 49) == 0), 10);
      end
      repeat (40) applyStimulus(0, 4, 0, 0);
      @(posedge clock); #1;
      checkOutput("finalDrain", 64'(countOut), 64'd0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clock); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
